net_access_ctrl: RTL and testbench

Transmit-side line access controller for the Econet interface, clocked on mclk. It arbitrates the single transmitter between two requesters: the automatic acknowledge generator, which has high priority, and the host path fed from SPI. It waits for the network line to be idle and clocked, then sequences flag_fill, tx_go and tx_abort. It also gates rx_enable and reports a per-frame completion status to the granted requester.

---
 rtl/net_access_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_net_access_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/net_access_ctrl.sv
// Econet transmit-side line access controller: arbitrates the transmitter between the
// ack generator and the host path, then sequences line settle, flag fill, send and abort.
module net_access_ctrl #(
  parameter int unsigned SETTLE       = 16,
  parameter int unsigned FILL         = 8,
  parameter int unsigned BUSY_TO      = 65535,
  parameter int unsigned START_TO     = 1024,
  parameter bit          RX_DURING_TX = 1'b0
) (
  input  logic       mclk,
  input  logic       reset_n,
  input  logic       ack_req,
  output logic       ack_gnt,
  input  logic       host_req,
  output logic       host_gnt,
  output logic       done,
  output logic [1:0] status,
  input  logic       idle,
  input  logic       no_clock,
  input  logic       txen,
  input  logic       tx_jabber,
  input  logic       tx_error,
  output logic       flag_fill,
  output logic       tx_go,
  output logic       tx_abort,
  output logic       rx_enable
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_ABORT = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_NOCLK = 2'b01;
  localparam logic [1:0] ST_BUSY  = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  localparam logic [15:0] SETTLE_C   = SETTLE[15:0];
  localparam logic [15:0] FILL_C     = FILL[15:0];
  localparam logic [15:0] BUSY_C     = BUSY_TO[15:0];
  localparam logic [15:0] START_C    = START_TO[15:0];

  logic [3:0]  sync1, sync2;
  logic        idle_s, no_clock_s, txen_s, jabber_s;
  logic [2:0]  state, state_d;
  logic        owner_ack, owner_d;
  logic [15:0] cnt, cnt_d, dwell, dwell_d;
  logic        txen_seen, seen_d;
  logic [1:0]  status_q, status_d;
  logic        run;
  logic        req_own;
  logic        fault;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Two-flop synchronisers for the netclk-domain line status inputs.
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {tx_jabber, txen, no_clock, idle};
      sync2 <= sync1;
    end
  end

  assign idle_s     = sync2[0];
  assign no_clock_s = sync2[1];
  assign txen_s     = sync2[2];
  assign jabber_s   = sync2[3];

  assign req_own = owner_ack ? ack_req : host_req;
  assign fault   = tx_error || jabber_s;

  // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    state_d  = state;
    owner_d  = owner_ack;
    cnt_d    = sat_inc(cnt);
    dwell_d  = dwell;
    seen_d   = txen_seen;
    status_d = status_q;
    case (state)
      S_IDLE: begin
        cnt_d   = '0;
        dwell_d = '0;
        seen_d  = 1'b0;
        if (ack_req) begin
          owner_d = 1'b1;
          state_d = S_WAIT;
        end else if (host_req) begin
          owner_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        dwell_d = sat_inc(dwell);
        cnt_d   = idle_s ? sat_inc(cnt) : '0;
        if (!req_own) begin
          state_d = S_IDLE;
        end else if (no_clock_s) begin
          state_d  = S_DONE;
          status_d = ST_NOCLK;
        end else if (idle_s && sat_inc(cnt) >= SETTLE_C) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end else if (sat_inc(dwell) >= BUSY_C) begin
          state_d  = S_DONE;
          status_d = ST_BUSY;
        end
      end
      S_FILL: begin
        if (!req_own) begin
          state_d = S_IDLE;
        end else if (sat_inc(cnt) >= FILL_C) begin
          state_d = S_SEND;
          cnt_d   = '0;
        end
      end
      S_SEND: begin
        if (txen_s) seen_d = 1'b1;
        if (fault) begin
          state_d = S_ABORT;
        end else if (txen_seen || txen_s) begin
          if (!req_own) state_d = S_DRAIN;
        end else if (sat_inc(cnt) >= START_C) begin
          state_d = S_ABORT;
        end
      end
      S_DRAIN: begin
        if (fault) begin
          state_d = S_ABORT;
        end else if (!txen_s) begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end
      end
      S_ABORT: begin
        if (!txen_s) begin
          state_d  = S_DONE;
          status_d = ST_FAULT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: only control state is reset; there is no storage array here needing a reset-free path.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      owner_ack <= 1'b0;
      cnt       <= '0;
      dwell     <= '0;
      txen_seen <= 1'b0;
      status_q  <= ST_OK;
      run       <= 1'b0;
    end else begin
      state     <= state_d;
      owner_ack <= owner_d;
      cnt       <= cnt_d;
      dwell     <= dwell_d;
      txen_seen <= seen_d;
      status_q  <= status_d;
      run       <= 1'b1;
    end
  end

  // run holds rx_enable low through reset and for the first edge after release.
  assign ack_gnt   = owner_ack && (state != S_IDLE);
  assign host_gnt  = !owner_ack && (state != S_IDLE);
  assign flag_fill = (state == S_FILL) || (state == S_SEND);
  assign tx_go     = (state == S_SEND);
  assign tx_abort  = (state == S_ABORT);
  assign done      = (state == S_DONE);
  assign status    = status_q;
  assign rx_enable = run && (RX_DURING_TX ||
                     !((state == S_SEND) || (state == S_DRAIN) || (state == S_ABORT)));

endmodule

// File: tb/tb_net_access_ctrl.sv
// Self-checking bench for net_access_ctrl: directed scenarios plus randomised frames
// checked against a frame-level outcome model.
module tb_net_access_ctrl;
  localparam int SETTLE   = 16;
  localparam int FILL     = 8;
  localparam int BUSY_TO  = 100;
  localparam int START_TO = 1024;

  localparam int SIG_FLAG  = 0;
  localparam int SIG_GO    = 1;
  localparam int SIG_ABORT = 2;
  localparam int SIG_DONE  = 3;

  logic mclk = 1'b0;
  logic reset_n = 1'b0;
  logic ack_req = 1'b0, host_req = 1'b0;
  logic idle = 1'b0, no_clock = 1'b0, txen = 1'b0, tx_jabber = 1'b0, tx_error = 1'b0;
  logic ack_gnt, host_gnt, done, flag_fill, tx_go, tx_abort, rx_enable;
  logic [1:0] status;

  int checks = 0, passes = 0, fails = 0;
  int go_cyc = 0, done_cyc = 0, flag_cyc = 0, overlaps = 0;

  net_access_ctrl #(
    .SETTLE(SETTLE), .FILL(FILL), .BUSY_TO(BUSY_TO), .START_TO(START_TO), .RX_DURING_TX(1'b0)
  ) dut (
    .mclk(mclk), .reset_n(reset_n),
    .ack_req(ack_req), .ack_gnt(ack_gnt),
    .host_req(host_req), .host_gnt(host_gnt),
    .done(done), .status(status),
    .idle(idle), .no_clock(no_clock), .txen(txen), .tx_jabber(tx_jabber), .tx_error(tx_error),
    .flag_fill(flag_fill), .tx_go(tx_go), .tx_abort(tx_abort), .rx_enable(rx_enable)
  );

  always #5 mclk = ~mclk;

  always @(negedge mclk) begin
    if (tx_go) go_cyc++;
    if (done) done_cyc++;
    if (flag_fill) flag_cyc++;
    if (ack_gnt && host_gnt) overlaps++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SIG_FLAG:  return flag_fill;
      SIG_GO:    return tx_go;
      SIG_ABORT: return tx_abort;
      default:   return done;
    endcase
  endfunction

  // Waits (sampling on falling edges) for a DUT output to go high; an expired bound is a failure.
  task automatic wait_high(input int sel, input int limit, output int waited);
    waited = 0;
    while (!sig(sel) && waited < limit) begin
      @(negedge mclk);
      waited++;
    end
    if (!sig(sel)) check($sformatf("wait_timeout_sig%0d", sel), 0, 1);
  endtask

  // One complete frame; the expected outcome comes from the fault kind alone:
  // fault 0 = clean frame (status ok), 1 = tx_error, 2 = jabber pulse (both status fault).
  task automatic frame(input bit use_ack, input int txen_dly, input int hold,
                       input int fall_dly, input int fault);
    int w;
    logic [1:0] exp_status;
    exp_status = (fault != 0) ? 2'b11 : 2'b00;
    if (use_ack) ack_req = 1'b1; else host_req = 1'b1;
    @(negedge mclk);
    check("gnt_latency", use_ack ? ack_gnt : host_gnt, 1);
    check("gnt_exclusive", use_ack ? host_gnt : ack_gnt, 0);
    wait_high(SIG_FLAG, SETTLE + 10, w);
    check("settle_window", (w >= SETTLE && w <= SETTLE + 3), 1);
    wait_high(SIG_GO, FILL + 4, w);
    check("fill_length", w, FILL);
    check("rx_off_send", rx_enable, 0);
    repeat (txen_dly) @(negedge mclk);
    txen = 1'b1;
    if (fault == 0) begin
      repeat (hold) @(negedge mclk);
      check("still_sending", {tx_go, flag_fill}, 2'b11);
      if (use_ack) ack_req = 1'b0; else host_req = 1'b0;
      @(negedge mclk);
      check("go_drop", {tx_go, flag_fill}, 0);
      check("rx_off_drain", rx_enable, 0);
    end else begin
      repeat (hold / 2 + 3) @(negedge mclk);
      if (fault == 1) begin
        tx_error = 1'b1;
        @(negedge mclk);
        tx_error = 1'b0;
        check("abort_error_latency", tx_abort, 1);
      end else begin
        tx_jabber = 1'b1;
        @(negedge mclk);
        tx_jabber = 1'b0;
        wait_high(SIG_ABORT, 6, w);
        // One edge for the state change plus two synchroniser stages.
        check("abort_jabber_latency", (w + 1 >= 2 && w + 1 <= 3), 1);
      end
      check("abort_go_low", tx_go, 0);
      if (use_ack) ack_req = 1'b0; else host_req = 1'b0;
    end
    repeat (fall_dly) @(negedge mclk);
    txen = 1'b0;
    wait_high(SIG_DONE, 12, w);
    check("done_status", status, exp_status);
    check("done_gnt_held", use_ack ? ack_gnt : host_gnt, 1);
    @(negedge mclk);
    check("done_one_cycle", {done, ack_gnt, host_gnt}, 0);
  endtask

  initial begin
    int w, g, d, go0, done0, flag0;
    logic [1:0] st;

    // Reset state
    repeat (2) @(negedge mclk);
    check("reset_outputs",
          {ack_gnt, host_gnt, done, status, flag_fill, tx_go, tx_abort, rx_enable}, 0);
    idle = 1'b1;
    reset_n = 1'b1;
    @(negedge mclk);
    check("rx_after_reset", rx_enable, 1);
    repeat (3) @(negedge mclk);

    // Basic frame from the test plan
    frame(1'b0, 3, 50, 4, 0);
    @(negedge mclk);

    // Simultaneous requests: ack wins, host follows one idle cycle after done
    host_req = 1'b1;
    frame(1'b1, 2, 10, 2, 0);
    @(negedge mclk);
    check("host_after_ack", host_gnt, 1);
    done0 = done_cyc;
    host_req = 1'b0;
    @(negedge mclk);
    check("cancel_wait_gnt", host_gnt, 0);
    repeat (5) @(negedge mclk);
    check("cancel_wait_no_done", done_cyc - done0, 0);

    // Busy line: idle toggles every 10 cycles so the line never settles
    idle = 1'b0;
    repeat (3) @(negedge mclk);
    flag0 = flag_cyc;
    host_req = 1'b1;
    g = -1; d = -1; st = 2'b00;
    for (int k = 1; k <= 130 && d < 0; k++) begin
      @(negedge mclk);
      idle = ((k / 10) % 2) == 1;
      if (g < 0 && host_gnt) g = k;
      if (done) begin
        d = k;
        st = status;
        host_req = 1'b0;
      end
    end
    check("busy_timeout_cycle", d - g, BUSY_TO);
    check("busy_status", st, 2'b10);
    check("busy_no_fill", flag_cyc - flag0, 0);
    idle = 1'b1;
    repeat (4) @(negedge mclk);

    // Dead line: no network clock
    no_clock = 1'b1;
    repeat (3) @(negedge mclk);
    host_req = 1'b1;
    wait_high(SIG_DONE, 10, w);
    check("noclk_status", status, 2'b01);
    host_req = 1'b0;
    no_clock = 1'b0;
    repeat (4) @(negedge mclk);

    // Jabber fault mid-SEND from the test plan
    frame(1'b0, 3, 10, 3, 2);
    @(negedge mclk);

    // Transmitter never starts: abort exactly START_TO cycles after tx_go
    host_req = 1'b1;
    wait_high(SIG_GO, SETTLE + FILL + 10, w);
    wait_high(SIG_ABORT, START_TO + 5, w);
    check("start_timeout_cycle", w, START_TO);
    check("start_timeout_go_low", tx_go, 0);
    host_req = 1'b0;
    wait_high(SIG_DONE, 10, w);
    check("start_timeout_status", status, 2'b11);
    repeat (2) @(negedge mclk);

    // Cancel during FILL
    host_req = 1'b1;
    wait_high(SIG_FLAG, SETTLE + 10, w);
    repeat (3) @(negedge mclk);
    go0 = go_cyc;
    done0 = done_cyc;
    host_req = 1'b0;
    @(negedge mclk);
    check("cancel_fill_outputs", {flag_fill, host_gnt}, 0);
    repeat (20) @(negedge mclk);
    check("cancel_fill_no_go", go_cyc - go0, 0);
    check("cancel_fill_no_done", done_cyc - done0, 0);

    // Randomised frames against the frame-level model
    for (int n = 0; n < 8; n++) begin
      frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)), int'($urandom_range(3, 30)),
            int'($urandom_range(1, 8)), int'($urandom_range(0, 2)));
      repeat (int'($urandom_range(1, 3))) @(negedge mclk);
    end

    // Reset asserted during SEND
    host_req = 1'b1;
    wait_high(SIG_GO, SETTLE + FILL + 10, w);
    repeat (2) @(negedge mclk);
    txen = 1'b1;
    repeat (4) @(negedge mclk);
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid_frame",
          {ack_gnt, host_gnt, done, status, flag_fill, tx_go, tx_abort, rx_enable}, 0);
    host_req = 1'b0;
    txen = 1'b0;
    @(negedge mclk);
    reset_n = 1'b1;
    @(negedge mclk);
    check("rx_after_rerelease", rx_enable, 1);
    repeat (3) @(negedge mclk);
    frame(1'b0, 1, 5, 3, 0);

    check("grants_never_overlap", overlaps, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
